i2c_frame_ctr: RTL and testbench

Parametrised I2C receive-side bit/byte/frame counter with ACK-slot tracking. Sits between the I2C bit sampler (start/stop detection, SCL strobe, sampled SDA) and the filter's byte-assembly and frame-capture logic. Successor to the fixed 8-bit, fixed-length counter: configurable byte width and frame length, explicit START/STOP framing, ACK/NACK checking and error reporting.

---
 rtl/i2c_frame_ctr.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_frame_ctr.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_ctr.sv
// ---------------------------------------------------------------------------
// i2c_frame_ctr
//
// Receive-side bit/byte/frame counter for an I2C filter. Consumes START/STOP
// and SCL-rising strobes from the bit sampler and tracks the bit index inside
// the current byte, the number of completed bytes in the current frame, and
// the ACK slot that follows every byte.
//
// Optional feature macro: I2C_CTR_NACK_ABORT_EN
//   defined     : a NACK in the ACK slot aborts the frame (-> ERR, byte dropped)
//   not defined : a NACK is recorded in nack_out but the byte is still accepted
//
// Parameters
//   DATA_BITS    data bits per byte (>= 2); an ACK slot follows every byte
//   FRAME_BYTES  bytes per frame (>= 1)
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   clr_in         synchronous clear to IDLE, highest priority
//   start_in       START / repeated START strobe
//   stop_in        STOP strobe
//   next_in        SCL rising-edge strobe, sda_in valid in the same cycle
//   sda_in         sampled SDA, only looked at in the ACK slot
//   bitctr_out     bit index within the current byte (DATA_BITS = ACK slot)
//   bytectr_out    completed bytes in the current frame
//   ack_slot_out   level, FSM in ACK
//   byteok_out     one-cycle pulse per accepted byte
//   frameok_out    level, FSM in DONE
//   nack_out       sticky NACK flag for the current frame
//   error_out      level, FSM in ERR
//   state_dbg_out  current FSM state encoding (observation only)
//
// Strobe handshake: every *_in strobe is a single-cycle, fire-and-forget
// event with no backpressure. Per cycle only the highest-priority strobe
// acts (clr_in > stop_in > start_in > next_in); the rest are dropped.
// ---------------------------------------------------------------------------
package myfilter_pkg;
  localparam int I2C_FRAME_BYTES = 3;
endpackage

module i2c_frame_ctr #(
  parameter int DATA_BITS   = 8,
  parameter int FRAME_BYTES = myfilter_pkg::I2C_FRAME_BYTES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_in,
  input  logic                             start_in,
  input  logic                             stop_in,
  input  logic                             next_in,
  input  logic                             sda_in,
  output logic [$clog2(DATA_BITS+1)-1:0]   bitctr_out,
  output logic [$clog2(FRAME_BYTES+1)-1:0] bytectr_out,
  output logic                             ack_slot_out,
  output logic                             byteok_out,
  output logic                             frameok_out,
  output logic                             nack_out,
  output logic                             error_out,
  output logic [2:0]                       state_dbg_out
);

  localparam int BW = $clog2(DATA_BITS+1);
  localparam int YW = $clog2(FRAME_BYTES+1);

  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS-1);
  localparam logic [BW-1:0] BIT_ACK   = BW'(DATA_BITS);
  localparam logic [YW-1:0] BYTE_ONE  = YW'(1);
  localparam logic [YW-1:0] BYTE_LAST = YW'(FRAME_BYTES-1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_ACK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [YW-1:0]   byte_q, byte_d;
  logic            nack_q, nack_d;
  logic            byteok_q, byteok_d;
  logic            ack_slot_q, frameok_q, error_q;

  // Next-state logic. "Fresh frame" (counters and NACK cleared, enter DATA)
  // is shared by IDLE, DONE (repeated START) and ERR.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    nack_d   = nack_q;
    byteok_d = 1'b0;

    if (clr_in) begin
      state_d = S_IDLE;
      bit_d   = '0;
      byte_d  = '0;
      nack_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ERR: begin
          // stop_in outranks start_in, and is itself ignored here
          if (!stop_in && start_in) begin
            state_d = S_DATA;
            bit_d   = '0;
            byte_d  = '0;
            nack_d  = 1'b0;
          end
        end

        S_DATA: begin
          if (stop_in || start_in) begin
            state_d = S_ERR;
          end else if (next_in) begin
            if (bit_q == BIT_LAST) begin
              state_d = S_ACK;
              bit_d   = BIT_ACK;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end
        end

        S_ACK: begin
          if (stop_in || start_in) begin
            state_d = S_ERR;
          end else if (next_in) begin
            if (sda_in) nack_d = 1'b1;
`ifdef I2C_CTR_NACK_ABORT_EN
            if (sda_in) begin
              state_d = S_ERR;
            end else begin
              byteok_d = 1'b1;
              bit_d    = '0;
              byte_d   = byte_q + BYTE_ONE;
              state_d  = (byte_q == BYTE_LAST) ? S_DONE : S_DATA;
            end
`else
            byteok_d = 1'b1;
            bit_d    = '0;
            byte_d   = byte_q + BYTE_ONE;
            state_d  = (byte_q == BYTE_LAST) ? S_DONE : S_DATA;
`endif
          end
        end

        S_DONE: begin
          if (stop_in) begin
            state_d = S_IDLE;
            bit_d   = '0;
            byte_d  = '0;
            nack_d  = 1'b0;
          end else if (start_in) begin
            state_d = S_DATA;
            bit_d   = '0;
            byte_d  = '0;
            nack_d  = 1'b0;
          end
        end

        default: begin
          state_d = S_IDLE;
          bit_d   = '0;
          byte_d  = '0;
          nack_d  = 1'b0;
        end
      endcase
    end
  end

  // State and all outputs are registered; the level outputs are decoded from
  // the next state so they change in the same cycle as state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_q      <= '0;
      byte_q     <= '0;
      nack_q     <= 1'b0;
      byteok_q   <= 1'b0;
      ack_slot_q <= 1'b0;
      frameok_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      nack_q     <= nack_d;
      byteok_q   <= byteok_d;
      ack_slot_q <= (state_d == S_ACK);
      frameok_q  <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERR);
    end
  end

  assign bitctr_out    = bit_q;
  assign bytectr_out   = byte_q;
  assign ack_slot_out  = ack_slot_q;
  assign byteok_out    = byteok_q;
  assign frameok_out   = frameok_q;
  assign nack_out      = nack_q;
  assign error_out     = error_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_i2c_frame_ctr.sv
// ---------------------------------------------------------------------------
// tb_i2c_frame_ctr
//
// Drives two instances in parallel with identical strobes:
//   inst 0 : DATA_BITS=8, FRAME_BYTES=3
//   inst 1 : DATA_BITS=4, FRAME_BYTES=1
// A frame-level model (phase, bits seen, bytes accepted, NACK flag) predicts
// every output after every clock; directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_i2c_frame_ctr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, start = 1'b0, stop = 1'b0, nxt = 1'b0, sda = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] a_bitctr;
  logic [1:0] a_bytectr;
  logic       a_ack, a_byteok, a_frameok, a_nack, a_error;
  logic [2:0] a_state;
  logic [2:0] b_bitctr;
  logic [0:0] b_bytectr;
  logic       b_ack, b_byteok, b_frameok, b_nack, b_error;
  logic [2:0] b_state;

  i2c_frame_ctr #(.DATA_BITS(8), .FRAME_BYTES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_in(clr), .start_in(start), .stop_in(stop),
    .next_in(nxt), .sda_in(sda), .bitctr_out(a_bitctr), .bytectr_out(a_bytectr),
    .ack_slot_out(a_ack), .byteok_out(a_byteok), .frameok_out(a_frameok),
    .nack_out(a_nack), .error_out(a_error), .state_dbg_out(a_state)
  );

  i2c_frame_ctr #(.DATA_BITS(4), .FRAME_BYTES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_in(clr), .start_in(start), .stop_in(stop),
    .next_in(nxt), .sda_in(sda), .bitctr_out(b_bitctr), .bytectr_out(b_bytectr),
    .ack_slot_out(b_ack), .byteok_out(b_byteok), .frameok_out(b_frameok),
    .nack_out(b_nack), .error_out(b_error), .state_dbg_out(b_state)
  );

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_ACTIVE = 1, PH_DONE = 2, PH_ERR = 3;
  int db[2] = '{8, 4};
  int fb[2] = '{3, 1};
  int m_ph[2], m_bits[2], m_bytes[2], m_nack[2], m_ok[2];

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = PH_IDLE; m_bits[k] = 0; m_bytes[k] = 0; m_nack[k] = 0; m_ok[k] = 0;
    end
  endtask

  task automatic model_fresh(input int k);
    m_ph[k] = PH_ACTIVE; m_bits[k] = 0; m_bytes[k] = 0; m_nack[k] = 0;
  endtask

  task automatic model_update(input int k, input bit c, input bit st, input bit sp,
                              input bit nx, input bit sd);
    m_ok[k] = 0;
    if (c) begin
      m_ph[k] = PH_IDLE; m_bits[k] = 0; m_bytes[k] = 0; m_nack[k] = 0;
    end else if (sp) begin
      if (m_ph[k] == PH_ACTIVE) m_ph[k] = PH_ERR;
      else if (m_ph[k] == PH_DONE) begin
        m_ph[k] = PH_IDLE; m_bits[k] = 0; m_bytes[k] = 0; m_nack[k] = 0;
      end
    end else if (st) begin
      if (m_ph[k] == PH_ACTIVE) m_ph[k] = PH_ERR;
      else model_fresh(k);
    end else if (nx && m_ph[k] == PH_ACTIVE) begin
      if (m_bits[k] < db[k]) begin
        m_bits[k]++;
      end else begin
        // the ACK slot is the (DATA_BITS+1)-th clock of a byte
        if (sd) m_nack[k] = 1;
`ifdef I2C_CTR_NACK_ABORT_EN
        if (sd) begin
          m_ph[k] = PH_ERR;
        end else begin
          m_ok[k] = 1; m_bits[k] = 0; m_bytes[k]++;
          if (m_bytes[k] == fb[k]) m_ph[k] = PH_DONE;
        end
`else
        m_ok[k] = 1; m_bits[k] = 0; m_bytes[k]++;
        if (m_bytes[k] == fb[k]) m_ph[k] = PH_DONE;
`endif
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("a_bitctr",  int'(a_bitctr),  m_bits[0]);
    cmp("a_bytectr", int'(a_bytectr), m_bytes[0]);
    cmp("a_ack",     int'(a_ack),     int'(m_ph[0] == PH_ACTIVE && m_bits[0] == db[0]));
    cmp("a_byteok",  int'(a_byteok),  m_ok[0]);
    cmp("a_frameok", int'(a_frameok), int'(m_ph[0] == PH_DONE));
    cmp("a_nack",    int'(a_nack),    m_nack[0]);
    cmp("a_error",   int'(a_error),   int'(m_ph[0] == PH_ERR));
    cmp("b_bitctr",  int'(b_bitctr),  m_bits[1]);
    cmp("b_bytectr", int'(b_bytectr), m_bytes[1]);
    cmp("b_ack",     int'(b_ack),     int'(m_ph[1] == PH_ACTIVE && m_bits[1] == db[1]));
    cmp("b_byteok",  int'(b_byteok),  m_ok[1]);
    cmp("b_frameok", int'(b_frameok), int'(m_ph[1] == PH_DONE));
    cmp("b_nack",    int'(b_nack),    m_nack[1]);
    cmp("b_error",   int'(b_error),   int'(m_ph[1] == PH_ERR));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit c, input bit st, input bit sp, input bit nx, input bit sd);
    clr = c; start = st; stop = sp; nxt = nx; sda = sd;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_update(k, c, st, sp, nx, sd);
    clr = 0; start = 0; stop = 0; nxt = 0; sda = 0;
    check_all();
  endtask

  task automatic nexts(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
  endtask

  initial begin
    // ---- reset ----
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    cmp("lit_reset_bitctr", int'(a_bitctr), 0);

    // ---- full frame ----
    step(0, 1, 0, 0, 0);
    nexts(4);
    cmp("lit_b_bitctr_max", int'(b_bitctr), 4);
    cmp("lit_b_ack_slot",   int'(b_ack), 1);
    nexts(1);
    cmp("lit_b_byteok",  int'(b_byteok), 1);
    cmp("lit_b_frameok", int'(b_frameok), 1);
    nexts(4);
    cmp("lit_a_byteok_9",  int'(a_byteok), 1);
    cmp("lit_a_bytectr_9", int'(a_bytectr), 1);
    nexts(18);
    cmp("lit_a_byteok_27",  int'(a_byteok), 1);
    cmp("lit_a_frameok_27", int'(a_frameok), 1);
    cmp("lit_a_bytectr_27", int'(a_bytectr), 3);
    step(0, 0, 1, 0, 0);
    cmp("lit_stop_frameok", int'(a_frameok), 0);

    // ---- short frame ----
    step(0, 1, 0, 0, 0);
    nexts(12);
    step(0, 0, 1, 0, 0);
    cmp("lit_short_error",   int'(a_error), 1);
    cmp("lit_short_bytectr", int'(a_bytectr), 1);
    cmp("lit_short_bitctr",  int'(a_bitctr), 3);
    step(0, 1, 0, 0, 0);
    cmp("lit_restart_error",   int'(a_error), 0);
    cmp("lit_restart_bytectr", int'(a_bytectr), 0);

    // ---- NACK in first ACK slot ----
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    nexts(8);
    step(0, 0, 0, 1, 1);
    cmp("lit_nack_flag", int'(a_nack), 1);
`ifdef I2C_CTR_NACK_ABORT_EN
    cmp("lit_nack_error",   int'(a_error), 1);
    cmp("lit_nack_byteok",  int'(a_byteok), 0);
    cmp("lit_nack_bytectr", int'(a_bytectr), 0);
`else
    cmp("lit_nack_error",   int'(a_error), 0);
    cmp("lit_nack_byteok",  int'(a_byteok), 1);
    cmp("lit_nack_bytectr", int'(a_bytectr), 1);
`endif

    // ---- repeated START after complete frame ----
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    nexts(27);
    step(0, 1, 0, 0, 0);
    cmp("lit_rs_bytectr", int'(a_bytectr), 0);
    cmp("lit_rs_frameok", int'(a_frameok), 0);
    cmp("lit_rs_error",   int'(a_error), 0);
    nexts(27);
    cmp("lit_rs_frame2", int'(a_frameok), 1);

    // ---- clr together with start and next mid-byte ----
    step(0, 1, 0, 0, 0);
    nexts(4);
    step(1, 1, 0, 1, 0);
    cmp("lit_clr_bitctr", int'(a_bitctr), 0);
    cmp("lit_clr_error",  int'(a_error), 0);

    // ---- async reset mid-ACK ----
    step(0, 1, 0, 0, 0);
    nexts(8);
    cmp("lit_pre_rst_ack", int'(a_ack), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    cmp("lit_post_rst_byteok", int'(a_byteok), 0);

    // ---- randomized traffic ----
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit c, st, sp, nx, sd;
      r = $urandom_range(0, 99);
      c = 0; st = 0; sp = 0; nx = 0;
      if (r < 2) c = 1;
      else if (r < 5) sp = 1;
      else if (r < 9) st = 1;
      else if (r < 80) nx = 1;
      if (c && $urandom_range(0, 1) == 1) nx = 1;
      sd = ($urandom_range(0, 9) == 0);
      step(c, st, sp, nx, sd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
